// File: rtl/sprite_motion_ctrl.sv
// Per-frame sprite motion scheduler: on each frame_tick it walks the sprite
// table one entry per clock, stepping each sprite and bouncing it off the playfield bounds.

module sprite_axis_step #(
  parameter int LEN  = 100,
  parameter int MINV = 50,
  parameter int MAXV = 600
) (
  input  logic [9:0] pos_i,
  input  logic [2:0] step_i,
  input  logic       dir_i,
  output logic [9:0] pos_o,
  output logic       dir_o
);
  localparam logic [10:0] LEN_W = 11'(LEN);
  localparam logic [10:0] MIN_W = 11'(MINV);
  localparam logic [10:0] MAX_W = 11'(MAXV);

  logic [10:0] pos_w, step_w, far_w;

  // 11-bit zero-extended math so neither the far edge nor the low compare can wrap
  always_comb begin
    pos_w  = {1'b0, pos_i};
    step_w = {8'd0, step_i};
    far_w  = pos_w + LEN_W + step_w;
    pos_o  = pos_i;
    dir_o  = dir_i;
    if (dir_i && (far_w > MAX_W)) begin
      dir_o = 1'b0;
      pos_o = 10'(MAX_W - LEN_W);
    end else if (!dir_i && (pos_w < (MIN_W + step_w))) begin
      dir_o = 1'b1;
      pos_o = 10'(MIN_W);
    end else if (dir_i) begin
      pos_o = 10'(pos_w + step_w);
    end else begin
      pos_o = 10'(pos_w - step_w);
    end
  end
endmodule

module sprite_motion_ctrl #(
  parameter int NUM_SPR = 4,
  parameter int IDX_W   = 2,
  parameter int SPR_W   = 100,
  parameter int SPR_H   = 100,
  parameter int X_MIN   = 50,
  parameter int X_MAX   = 600,
  parameter int Y_MIN   = 50,
  parameter int Y_MAX   = 400
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   frame_tick,
  input  logic                   cfg_we,
  input  logic [IDX_W-1:0]       cfg_idx,
  input  logic [9:0]             cfg_x,
  input  logic [9:0]             cfg_y,
  input  logic [2:0]             cfg_step,
  input  logic                   cfg_xdir,
  input  logic                   cfg_ydir,
  output logic                   cfg_ready,
  output logic                   busy,
  output logic                   upd_done,
  output logic                   overrun,
  output logic [NUM_SPR*10-1:0]  spr_x,
  output logic [NUM_SPR*10-1:0]  spr_y
);
  typedef enum logic [1:0] {S_IDLE, S_UPDATE, S_DONE} state_e;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_SPR - 1);

  state_e                   state_q, state_d;
  logic [IDX_W-1:0]         idx_q, idx_d;
  logic                     overrun_q, overrun_d;

  logic [NUM_SPR-1:0][9:0]  x_q, y_q;
  logic [NUM_SPR-1:0][2:0]  step_q;
  logic [NUM_SPR-1:0]       xdir_q, ydir_q;

  logic [9:0]               cur_x, cur_y, nxt_x, nxt_y;
  logic [2:0]               cur_step;
  logic                     cur_xdir, cur_ydir, nxt_xdir, nxt_ydir;
  logic                     idx_ok, wr_en, upd_en;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      S_IDLE: if (frame_tick) begin
        state_d = S_UPDATE;
        idx_d   = '0;
      end
      S_UPDATE: begin
        if (idx_q == LAST_IDX) state_d = S_DONE;
        else                   idx_d   = idx_q + 1'b1;
      end
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      idx_q     <= '0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      overrun_q <= overrun_d;
    end
  end

  assign cfg_ready = (state_q == S_IDLE);
  assign busy      = (state_q == S_UPDATE) || (state_q == S_DONE);
  assign upd_done  = (state_q == S_DONE);
  assign overrun   = overrun_q;
  assign overrun_d = overrun_q | (frame_tick & busy);

  assign idx_ok = ({1'b0, cfg_idx} < (IDX_W+1)'(NUM_SPR));
  assign wr_en  = cfg_we & cfg_ready & idx_ok;
  assign upd_en = (state_q == S_UPDATE);

  // Select the entry being walked; compare-based so idx never reads past the table
  always_comb begin
    cur_x    = '0;
    cur_y    = '0;
    cur_step = '0;
    cur_xdir = 1'b0;
    cur_ydir = 1'b0;
    for (int k = 0; k < NUM_SPR; k++) begin
      if (idx_q == IDX_W'(k)) begin
        cur_x    = x_q[k];
        cur_y    = y_q[k];
        cur_step = step_q[k];
        cur_xdir = xdir_q[k];
        cur_ydir = ydir_q[k];
      end
    end
  end

  sprite_axis_step #(.LEN(SPR_W), .MINV(X_MIN), .MAXV(X_MAX)) u_ax_x (
    .pos_i  (cur_x),
    .step_i (cur_step),
    .dir_i  (cur_xdir),
    .pos_o  (nxt_x),
    .dir_o  (nxt_xdir)
  );

  sprite_axis_step #(.LEN(SPR_H), .MINV(Y_MIN), .MAXV(Y_MAX)) u_ax_y (
    .pos_i  (cur_y),
    .step_i (cur_step),
    .dir_i  (cur_ydir),
    .pos_o  (nxt_y),
    .dir_o  (nxt_ydir)
  );

  // Writes only happen in IDLE and updates only in UPDATE, so they never collide
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < NUM_SPR; k++) begin
        x_q[k]    <= 10'(X_MIN);
        y_q[k]    <= 10'(Y_MIN);
        step_q[k] <= 3'd1;
        xdir_q[k] <= 1'b1;
        ydir_q[k] <= 1'b1;
      end
    end else begin
      for (int k = 0; k < NUM_SPR; k++) begin
        if (wr_en && (cfg_idx == IDX_W'(k))) begin
          x_q[k]    <= cfg_x;
          y_q[k]    <= cfg_y;
          step_q[k] <= cfg_step;
          xdir_q[k] <= cfg_xdir;
          ydir_q[k] <= cfg_ydir;
        end else if (upd_en && (idx_q == IDX_W'(k))) begin
          x_q[k]    <= nxt_x;
          y_q[k]    <= nxt_y;
          xdir_q[k] <= nxt_xdir;
          ydir_q[k] <= nxt_ydir;
        end
      end
    end
  end

  assign spr_x = x_q;
  assign spr_y = y_q;
endmodule

// File: tb/tb_sprite_motion_ctrl.sv
// Bench for sprite_motion_ctrl: a 4-sprite and a 3-sprite instance share stimulus
// and are compared against an integer model of the bounce rules.

module tb_sprite_motion_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic frame_tick = 1'b0;
  logic cfg_we = 1'b0;
  logic [1:0] cfg_idx = '0;
  logic [9:0] cfg_x = '0, cfg_y = '0;
  logic [2:0] cfg_step = '0;
  logic cfg_xdir = 1'b0, cfg_ydir = 1'b0;

  logic rdy4, busy4, done4, ovr4, rdy3, busy3, done3, ovr3;
  logic [39:0] spr_x4, spr_y4;
  logic [29:0] spr_x3, spr_y3;

  int n_cmp = 0;
  int n_bad = 0;

  // model: [0] = 4-sprite build, [1] = 3-sprite build
  int mx[2][4], my[2][4], ms[2][4], mxd[2][4], myd[2][4];

  always #5 clk = ~clk;

  sprite_motion_ctrl #(.NUM_SPR(4), .IDX_W(2)) dut (
    .clk(clk), .rst(rst), .frame_tick(frame_tick), .cfg_we(cfg_we), .cfg_idx(cfg_idx),
    .cfg_x(cfg_x), .cfg_y(cfg_y), .cfg_step(cfg_step), .cfg_xdir(cfg_xdir), .cfg_ydir(cfg_ydir),
    .cfg_ready(rdy4), .busy(busy4), .upd_done(done4), .overrun(ovr4),
    .spr_x(spr_x4), .spr_y(spr_y4)
  );

  sprite_motion_ctrl #(.NUM_SPR(3), .IDX_W(2)) dut3 (
    .clk(clk), .rst(rst), .frame_tick(frame_tick), .cfg_we(cfg_we), .cfg_idx(cfg_idx),
    .cfg_x(cfg_x), .cfg_y(cfg_y), .cfg_step(cfg_step), .cfg_xdir(cfg_xdir), .cfg_ydir(cfg_ydir),
    .cfg_ready(rdy3), .busy(busy3), .upd_done(done3), .overrun(ovr3),
    .spr_x(spr_x3), .spr_y(spr_y3)
  );

  function automatic int ns(input int w);
    return (w == 0) ? 4 : 3;
  endfunction

  function automatic void axis(input int p, input int d, input int s, input int len,
                               input int lo, input int hi, output int po, output int dout);
    po = p; dout = d;
    if (d == 1 && p + len + s > hi) begin dout = 0; po = hi - len; end
    else if (d == 0 && p < lo + s) begin dout = 1; po = lo; end
    else po = (d == 1) ? p + s : p - s;
  endfunction

  function automatic void model_reset();
    for (int w = 0; w < 2; w++)
      for (int k = 0; k < 4; k++) begin
        mx[w][k] = 50; my[w][k] = 50; ms[w][k] = 1; mxd[w][k] = 1; myd[w][k] = 1;
      end
  endfunction

  function automatic void model_write(input int idx, x, y, s, xd, yd);
    for (int w = 0; w < 2; w++)
      if (idx < ns(w)) begin
        mx[w][idx] = x; my[w][idx] = y; ms[w][idx] = s; mxd[w][idx] = xd; myd[w][idx] = yd;
      end
  endfunction

  function automatic void model_frame();
    for (int w = 0; w < 2; w++)
      for (int k = 0; k < ns(w); k++) begin
        axis(mx[w][k], mxd[w][k], ms[w][k], 100, 50, 600, mx[w][k], mxd[w][k]);
        axis(my[w][k], myd[w][k], ms[w][k], 100, 50, 400, my[w][k], myd[w][k]);
      end
  endfunction

  function automatic logic [39:0] pack(input int w, input bit ya);
    logic [39:0] v;
    v = '0;
    for (int k = 0; k < ns(w); k++) v[k*10 +: 10] = 10'(ya ? my[w][k] : mx[w][k]);
    return v;
  endfunction

  // stimulus only: write entry in IDLE
  task automatic cfg_write(input int idx, x, y, s, xd, yd);
    @(negedge clk);
    cfg_we = 1'b1; cfg_idx = 2'(idx); cfg_x = 10'(x); cfg_y = 10'(y);
    cfg_step = 3'(s); cfg_xdir = xd[0]; cfg_ydir = yd[0];
    @(negedge clk);
    cfg_we = 1'b0;
    model_write(idx, x, y, s, xd, yd);
  endtask

  // stimulus only: one full frame, optionally with a write in the tick cycle; ends in IDLE
  task automatic run_frame(input bit we, input int idx, x, y, s, xd, yd);
    @(negedge clk);
    frame_tick = 1'b1;
    cfg_we = we; cfg_idx = 2'(idx); cfg_x = 10'(x); cfg_y = 10'(y);
    cfg_step = 3'(s); cfg_xdir = xd[0]; cfg_ydir = yd[0];
    if (we) model_write(idx, x, y, s, xd, yd);
    model_frame();
    @(negedge clk);
    frame_tick = 1'b0; cfg_we = 1'b0;
    repeat (5) @(negedge clk);
  endtask

  task automatic test_reset();
    @(negedge clk);
    n_cmp++; if (spr_x4 !== {4{10'd50}}) begin n_bad++; $display("FAIL reset_x got %h want %h", spr_x4, {4{10'd50}}); end
    n_cmp++; if (spr_y4 !== {4{10'd50}}) begin n_bad++; $display("FAIL reset_y got %h want %h", spr_y4, {4{10'd50}}); end
    n_cmp++; if (spr_x3 !== {3{10'd50}}) begin n_bad++; $display("FAIL reset_x3 got %h", spr_x3); end
    n_cmp++; if ({rdy4, busy4, done4, ovr4} !== 4'b1000) begin n_bad++; $display("FAIL reset_flags got %b want 1000", {rdy4, busy4, done4, ovr4}); end
    rst = 1'b0;
  endtask

  task automatic test_basic_frame();
    logic [39:0] ox, nx, ex;
    ox = pack(0, 0);
    model_frame();
    nx = pack(0, 0);
    @(negedge clk);
    frame_tick = 1'b1;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      frame_tick = 1'b0;
      for (int k = 0; k < 4; k++) ex[k*10 +: 10] = (k <= c - 2) ? nx[k*10 +: 10] : ox[k*10 +: 10];
      n_cmp++; if (spr_x4 !== ex) begin n_bad++; $display("FAIL frame_lane_timing c=%0d got %h want %h", c, spr_x4, ex); end
      n_cmp++; if (done4 !== (c == 5)) begin n_bad++; $display("FAIL upd_done c=%0d got %b want %b", c, done4, c == 5); end
      n_cmp++; if (busy4 !== (c <= 5) || rdy4 !== (c > 5)) begin n_bad++; $display("FAIL busy_ready c=%0d got %b%b", c, busy4, rdy4); end
    end
    n_cmp++; if (spr_x4 !== {4{10'd51}} || spr_y4 !== {4{10'd51}}) begin n_bad++; $display("FAIL frame_51 got %h %h want all 51", spr_x4, spr_y4); end
    n_cmp++; if (spr_y3 !== pack(1, 1)) begin n_bad++; $display("FAIL frame_y3 got %h want %h", spr_y3, pack(1, 1)); end
  endtask

  task automatic test_right_bounce();
    int exp_x[3] = '{499, 500, 496};
    cfg_write(1, 495, 100, 4, 1, 1);
    for (int f = 0; f < 3; f++) begin
      run_frame(0, 0, 0, 0, 0, 0, 0);
      n_cmp++; if (spr_x4[19:10] !== 10'(exp_x[f])) begin n_bad++; $display("FAIL right_bounce f=%0d got %0d want %0d", f, spr_x4[19:10], exp_x[f]); end
    end
    n_cmp++; if (spr_x4 !== pack(0, 0) || spr_y4 !== pack(0, 1)) begin n_bad++; $display("FAIL right_bounce_tbl got %h want %h", spr_x4, pack(0, 0)); end
  endtask

  task automatic test_left_bounce();
    cfg_write(2, 52, 100, 3, 0, 1);
    run_frame(0, 0, 0, 0, 0, 0, 0);
    n_cmp++; if (spr_x4[29:20] !== 10'd50) begin n_bad++; $display("FAIL left_clamp got %0d want 50", spr_x4[29:20]); end
    run_frame(0, 0, 0, 0, 0, 0, 0);
    n_cmp++; if (spr_x4[29:20] !== 10'd53) begin n_bad++; $display("FAIL left_rebound got %0d want 53", spr_x4[29:20]); end
    cfg_write(2, 300, 298, 4, 1, 1);
    run_frame(0, 0, 0, 0, 0, 0, 0);
    n_cmp++; if (spr_y4[29:20] !== 10'd300) begin n_bad++; $display("FAIL y_clamp got %0d want 300", spr_y4[29:20]); end
    run_frame(0, 0, 0, 0, 0, 0, 0);
    n_cmp++; if (spr_y4[29:20] !== 10'd296) begin n_bad++; $display("FAIL y_rebound got %0d want 296", spr_y4[29:20]); end
    n_cmp++; if (spr_y3 !== pack(1, 1) || spr_x3 !== pack(1, 0)) begin n_bad++; $display("FAIL left_tbl3 got %h want %h", spr_x3, pack(1, 0)); end
  endtask

  task automatic test_overrun_and_abort();
    @(negedge clk);
    frame_tick = 1'b1;
    model_frame();
    @(negedge clk); frame_tick = 1'b0;
    @(negedge clk); frame_tick = 1'b1;
    @(negedge clk); frame_tick = 1'b0;
    n_cmp++; if (ovr4 !== 1'b1 || ovr3 !== 1'b1) begin n_bad++; $display("FAIL overrun_set got %b%b want 11", ovr4, ovr3); end
    repeat (3) @(negedge clk);
    n_cmp++; if (spr_x4 !== pack(0, 0) || spr_y4 !== pack(0, 1)) begin n_bad++; $display("FAIL overrun_single_update got %h want %h", spr_x4, pack(0, 0)); end
    run_frame(0, 0, 0, 0, 0, 0, 0);
    n_cmp++; if (ovr4 !== 1'b1 || rdy4 !== 1'b1) begin n_bad++; $display("FAIL overrun_sticky got %b", ovr4); end
    @(negedge clk); frame_tick = 1'b1;
    @(negedge clk); frame_tick = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    model_reset();
    n_cmp++; if (spr_x4 !== {4{10'd50}} || spr_y4 !== {4{10'd50}}) begin n_bad++; $display("FAIL abort_table got %h %h", spr_x4, spr_y4); end
    n_cmp++; if ({busy4, ovr4, rdy4, ovr3} !== 4'b0010) begin n_bad++; $display("FAIL abort_flags got %b want 0010", {busy4, ovr4, rdy4, ovr3}); end
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_cfg_handshake();
    @(negedge clk);
    frame_tick = 1'b1;
    model_frame();
    @(negedge clk); frame_tick = 1'b0;
    @(negedge clk);
    cfg_we = 1'b1; cfg_idx = 2'd0; cfg_x = 10'd300; cfg_y = 10'd300; cfg_step = 3'd7;
    @(negedge clk); cfg_we = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++; if (spr_x4[9:0] !== 10'd51) begin n_bad++; $display("FAIL busy_write_ignored got %0d want 51", spr_x4[9:0]); end
    run_frame(1, 3, 200, 100, 2, 1, 1);
    n_cmp++; if (spr_x4[39:30] !== 10'd202) begin n_bad++; $display("FAIL write_with_tick got %0d want 202", spr_x4[39:30]); end
    n_cmp++; if (spr_x4 !== pack(0, 0) || spr_x3 !== pack(1, 0)) begin n_bad++; $display("FAIL handshake_tbl got %h want %h", spr_x4, pack(0, 0)); end
  endtask

  task automatic test_out_of_range();
    logic [29:0] before3;
    cfg_write(0, 700, 100, 1, 1, 1);
    run_frame(0, 0, 0, 0, 0, 0, 0);
    n_cmp++; if (spr_x4[9:0] !== 10'd500) begin n_bad++; $display("FAIL oob_clamp got %0d want 500", spr_x4[9:0]); end
    run_frame(0, 0, 0, 0, 0, 0, 0);
    n_cmp++; if (spr_x4[9:0] !== 10'd499) begin n_bad++; $display("FAIL oob_flip got %0d want 499", spr_x4[9:0]); end
    before3 = spr_x3;
    cfg_write(3, 111, 222, 5, 0, 0);
    n_cmp++; if (spr_x3 !== before3 || spr_x4[39:30] !== 10'd111) begin n_bad++; $display("FAIL idx_drop got %h/%0d want %h/111", spr_x3, spr_x4[39:30], before3); end
    run_frame(0, 0, 0, 0, 0, 0, 0);
    n_cmp++; if (spr_y3 !== pack(1, 1) || spr_y4 !== pack(0, 1)) begin n_bad++; $display("FAIL idx_drop_frame got %h want %h", spr_y3, pack(1, 1)); end
  endtask

  task automatic test_random();
    for (int it = 0; it < 30; it++) begin
      for (int n = $urandom_range(0, 2); n > 0; n--)
        cfg_write($urandom_range(0, 3), $urandom_range(0, 1023), $urandom_range(0, 1023),
                  $urandom_range(0, 7), $urandom_range(0, 1), $urandom_range(0, 1));
      run_frame($urandom_range(0, 1) == 1, $urandom_range(0, 3), $urandom_range(0, 700),
                $urandom_range(0, 500), $urandom_range(0, 7), $urandom_range(0, 1), $urandom_range(0, 1));
      n_cmp++; if (spr_x4 !== pack(0, 0) || spr_y4 !== pack(0, 1)) begin n_bad++; $display("FAIL rand4 it=%0d got %h/%h want %h/%h", it, spr_x4, spr_y4, pack(0, 0), pack(0, 1)); end
      n_cmp++; if (spr_x3 !== pack(1, 0) || spr_y3 !== pack(1, 1)) begin n_bad++; $display("FAIL rand3 it=%0d got %h/%h want %h/%h", it, spr_x3, spr_y3, pack(1, 0), pack(1, 1)); end
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    model_reset();
    test_reset();
    test_basic_frame();
    test_right_bounce();
    test_left_bounce();
    test_overrun_and_abort();
    test_cfg_handshake();
    test_out_of_range();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
